// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, ALUOp,
// datapath mux selects, FSM states and the control-vector payload.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       instr_retired;
    } ctrl_t;

endpackage

// File: rtl/riscv_mc_ctrl_decode.sv
// State-to-control-vector table; only the FETCH/MEM_WR completion strobes and
// the BRANCH pc_write look past the state itself.
module riscv_mc_ctrl_decode
    import riscv_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read   = 1'b1;
                ctrl.adr_src    = ADR_PC;
                ctrl.alu_src_a  = SRC_A_PC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_write   = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.adr_src  = ADR_ALUOUT;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.result_src    = RES_MDR;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.adr_src       = ADR_ALUOUT;
                ctrl.mem_write     = 1'b1;
                ctrl.instr_retired = mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.result_src    = RES_ALUOUT;
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = SRC_A_RS1;
                ctrl.alu_src_b     = SRC_B_RS2;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.result_src    = RES_ALUOUT;
                ctrl.pc_write      = zero;
                ctrl.instr_retired = 1'b1;
            end
            // PC takes the target computed in DECODE while the ALU forms OldPC+4
            S_JAL: begin
                ctrl.alu_src_a  = SRC_A_OLDPC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath: state register,
// next-state logic, memory-wait timeout and sticky error flags.
module riscv_mc_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                adr_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          result_src,
    output logic                instr_retired,
    output logic                illegal_instr,
    output logic                bus_error,
    output logic [STATE_W-1:0]  state_o
);

    localparam bit              TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_EN ? TO_W'(MEM_TIMEOUT - 1) : '0;

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] to_cnt;
    logic            is_wait;
    logic            at_limit;
    logic            set_illegal;
    logic            set_bus_err;
    ctrl_t           ctrl;

    assign is_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign at_limit = TO_EN && (to_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a ready memory always beats an expiring timeout
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    case (state_q)
                        S_FETCH:  state_d = S_DECODE;
                        S_MEM_RD: state_d = S_MEM_WB;
                        default:  state_d = S_FETCH;
                    endcase
                end else if (at_limit) begin
                    state_d     = S_ERROR;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    default: begin
                        state_d     = S_ERROR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_WB:   state_d = S_FETCH;
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALU_WB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
    end

    // Wait-cycle counter, saturating so a disabled timeout never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_d != state_q) begin
            to_cnt <= '0;
        end else if (is_wait && !mem_ready && (to_cnt != '1)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            illegal_instr <= illegal_instr | set_illegal;
            bus_error     <= bus_error | set_bus_err;
        end
    end

    riscv_mc_ctrl_decode u_decode (
        .state     (state_q),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Strobes are held off combinationally for the whole reset assertion
    assign pc_write      = ctrl.pc_write      & rst_n;
    assign ir_write      = ctrl.ir_write      & rst_n;
    assign reg_write     = ctrl.reg_write     & rst_n;
    assign mem_read      = ctrl.mem_read      & rst_n;
    assign mem_write     = ctrl.mem_write     & rst_n;
    assign instr_retired = ctrl.instr_retired & rst_n;
    assign adr_src       = ctrl.adr_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign result_src    = ctrl.result_src;
    assign state_o       = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: walks each instruction class and the
// timeout/illegal paths, comparing state and the full control vector.
module tb_riscv_mc_ctrl;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                           ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5,
                           ST_EXEC_R = 4'd6, ST_EXEC_I = 4'd7, ST_ALU_WB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JAL = 4'd10, ST_ERROR = 4'd11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_retired, illegal_instr, bus_error;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    logic [14:0] ctl;
    assign ctl = {pc_write, ir_write, reg_write, mem_read, mem_write, adr_src,
                  alu_src_a, alu_src_b, alu_op, result_src, instr_retired};

    always #5 clk = ~clk;

    riscv_mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .state_o       (state_o)
    );

    function automatic logic [14:0] cv(input logic pw, input logic irw, input logic rw,
                                       input logic mr, input logic mw, input logic adr,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] res,
                                       input logic ret);
        return {pw, irw, rw, mr, mw, adr, a, b, op, res, ret};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [14:0] vec);
        chk({tag, "_state"}, 32'(state_o), 32'(st));
        chk({tag, "_ctl"}, 32'(ctl), 32'(vec));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input logic v);
        mem_ready = v;
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n     = 1'b0;
        mem_ready = rdy;
        @(posedge clk);
        #1;
        expect_st("rst", ST_FETCH, cv(0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd2,0));
        chk("rst_flags", 32'({illegal_instr, bus_error}), 32'd0);
        rst_n = 1'b1;
        #1;
    endtask

    logic [14:0] v_fetch_rdy, v_fetch_wait, v_dec, v_alu_wb;

    initial begin
        v_fetch_rdy  = cv(1,1,0,1,0,0,2'd0,2'd2,2'd0,2'd2,0);
        v_fetch_wait = cv(0,0,0,1,0,0,2'd0,2'd2,2'd0,2'd2,0);
        v_dec        = cv(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,0);
        v_alu_wb     = cv(0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,1);
        opcode = 7'b0110011;
        zero   = 1'b0;

        // ADD: 4 cycles
        do_reset(1'b1);
        expect_st("add_fetch", ST_FETCH, v_fetch_rdy);
        cyc(); expect_st("add_dec", ST_DECODE, v_dec);
        cyc(); expect_st("add_exec", ST_EXEC_R, cv(0,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0,0));
        cyc(); expect_st("add_wb", ST_ALU_WB, v_alu_wb);
        cyc(); expect_st("add_done", ST_FETCH, v_fetch_rdy);

        // LW with 3 wait cycles; ready arrives exactly at the limit count
        opcode = 7'b0000011;
        cyc(); expect_st("lw_dec", ST_DECODE, v_dec);
        cyc(); expect_st("lw_addr", ST_MEM_ADDR, cv(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0));
        drive_ready(1'b0);
        cyc(); expect_st("lw_rd1", ST_MEM_RD, cv(0,0,0,1,0,1,2'd0,2'd0,2'd0,2'd0,0));
        cyc(); expect_st("lw_rd2", ST_MEM_RD, cv(0,0,0,1,0,1,2'd0,2'd0,2'd0,2'd0,0));
        cyc(); expect_st("lw_rd3", ST_MEM_RD, cv(0,0,0,1,0,1,2'd0,2'd0,2'd0,2'd0,0));
        drive_ready(1'b1);
        expect_st("lw_rd4", ST_MEM_RD, cv(0,0,0,1,0,1,2'd0,2'd0,2'd0,2'd0,0));
        cyc(); expect_st("lw_wb", ST_MEM_WB, cv(0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd1,1));
        chk("lw_bus_err", 32'(bus_error), 32'd0);
        cyc(); expect_st("lw_done", ST_FETCH, v_fetch_rdy);

        // SW: one wait cycle then completion
        opcode = 7'b0100011;
        cyc(); cyc(); expect_st("sw_addr", ST_MEM_ADDR, cv(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0));
        drive_ready(1'b0);
        cyc(); expect_st("sw_wait", ST_MEM_WR, cv(0,0,0,0,1,1,2'd0,2'd0,2'd0,2'd0,0));
        drive_ready(1'b1);
        expect_st("sw_cmpl", ST_MEM_WR, cv(0,0,0,0,1,1,2'd0,2'd0,2'd0,2'd0,1));
        cyc(); expect_st("sw_done", ST_FETCH, v_fetch_rdy);

        // BEQ taken then not taken
        opcode = 7'b1100011;
        zero   = 1'b1;
        cyc(); cyc(); expect_st("beq_t", ST_BRANCH, cv(1,0,0,0,0,0,2'd2,2'd0,2'd1,2'd0,1));
        cyc(); expect_st("beq_t_done", ST_FETCH, v_fetch_rdy);
        zero = 1'b0;
        cyc(); cyc(); expect_st("beq_nt", ST_BRANCH, cv(0,0,0,0,0,0,2'd2,2'd0,2'd1,2'd0,1));
        cyc(); expect_st("beq_nt_done", ST_FETCH, v_fetch_rdy);

        // JAL
        opcode = 7'b1101111;
        cyc(); expect_st("jal_dec", ST_DECODE, v_dec);
        cyc(); expect_st("jal", ST_JAL, cv(1,0,0,0,0,0,2'd1,2'd2,2'd0,2'd0,0));
        cyc(); expect_st("jal_wb", ST_ALU_WB, v_alu_wb);
        cyc(); expect_st("jal_done", ST_FETCH, v_fetch_rdy);

        // ADDI
        opcode = 7'b0010011;
        cyc(); cyc(); expect_st("addi_exec", ST_EXEC_I, cv(0,0,0,0,0,0,2'd2,2'd1,2'd2,2'd0,0));
        cyc(); expect_st("addi_wb", ST_ALU_WB, v_alu_wb);
        cyc();

        // Unsupported opcode (LUI) lands in ERROR and stays there
        opcode = 7'b0110111;
        cyc(); expect_st("ill_dec", ST_DECODE, v_dec);
        cyc(); expect_st("ill_err", ST_ERROR, 15'd0);
        chk("ill_flag", 32'({illegal_instr, bus_error}), 32'b10);
        drive_ready(1'b0);
        cyc(); cyc(); expect_st("ill_hold", ST_ERROR, 15'd0);
        chk("ill_sticky", 32'(illegal_instr), 32'd1);

        // Reset mid-store drops mem_write immediately
        opcode = 7'b0100011;
        do_reset(1'b1);
        cyc(); cyc(); cyc();
        expect_st("rst_sw_wr", ST_MEM_WR, cv(0,0,0,0,1,1,2'd0,2'd0,2'd0,2'd0,1));
        rst_n = 1'b0;
        #1;
        chk("rst_sw_abort", 32'({mem_write, instr_retired, 4'(state_o)}), 32'(6'd0));
        rst_n = 1'b1;
        #1;

        // FETCH timeout with mem_ready stuck low
        do_reset(1'b0);
        expect_st("to_f0", ST_FETCH, v_fetch_wait);
        cyc(); cyc(); cyc();
        expect_st("to_f3", ST_FETCH, v_fetch_wait);
        cyc(); expect_st("to_err", ST_ERROR, 15'd0);
        chk("to_flags", 32'({illegal_instr, bus_error}), 32'b01);

        // Ready exactly at the limit count wins over the timeout
        do_reset(1'b0);
        cyc(); cyc(); cyc();
        drive_ready(1'b1);
        expect_st("lim_f3", ST_FETCH, v_fetch_rdy);
        cyc(); expect_st("lim_dec", ST_DECODE, v_dec);
        chk("lim_flags", 32'({illegal_instr, bus_error}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I datapath. Sequences fetch, decode, execute, memory and writeback over a shared ALU, shared memory port and shared register file.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = ADD, 01 = SUB/compare, 10 = funct decode.
- Handles variable-latency memory through a ready handshake, with a bus timeout.
- Sits between the instruction register's opcode field and all datapath mux selects and write enables.

Parameters:
- MEM_TIMEOUT, 16: max cycles to wait for mem_ready in a memory state; 0 disables the timeout.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag, combinational
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load
- ir_write  out  1  instruction register (and OldPC) load
- reg_write  out  1  register file write
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
- alu_op  out  2  to ALU control decoder
- result_src  out  2  00 = ALUOut, 01 = mem data register, 10 = ALU result direct
- instr_retired  out  1  one-cycle pulse when an instruction completes
- illegal_instr  out  1  sticky, unsupported opcode seen
- bus_error  out  1  sticky, memory timeout
- state_o  out  4  current state encoding, debug only

Behaviour:
- Outputs are Moore-decoded from the state register. The exceptions are pc_write in BRANCH (equal to zero) and the wait-state strobes gated by mem_ready.
- Unlisted outputs in any state are 0.
- Reset, asynchronous while rst_n = 0:
  - state = FETCH, timeout counter = 0, illegal_instr = bus_error = 0.
  - All strobes forced 0 while rst_n is low: pc_write, ir_write, reg_write, mem_read, mem_write, instr_retired.
- FETCH: mem_read=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
  - On mem_ready=1: ir_write=1, pc_write=1 in that same cycle, next state DECODE.
  - Otherwise hold.
- DECODE: src_a=01, src_b=01, alu_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> ERROR with illegal_instr set
- MEM_ADDR: src_a=10, src_b=01, alu_op=00. Next state MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: adr_src=1, mem_read=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1, instr_retired=1, next state FETCH.
- MEM_WR: adr_src=1, mem_write=1. Waits for mem_ready, then instr_retired=1 in that cycle and next state FETCH.
- EXEC_R: src_a=10, src_b=00, alu_op=10, next state ALU_WB.
- EXEC_I: src_a=10, src_b=01, alu_op=10, next state ALU_WB.
- ALU_WB: result_src=00, reg_write=1, instr_retired=1, next state FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00, pc_write=zero, instr_retired=1, next state FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <- target held in ALUOut), next state ALU_WB (rd <- OldPC+4).
- ERROR: all strobes 0. Terminal; exited only by reset.
- Timeout (wait states are FETCH, MEM_RD, MEM_WR):
  - Counter clears on every state change and increments each cycle spent in a wait state with mem_ready=0.
  - When the counter equals MEM_TIMEOUT-1 and mem_ready=0, next state is ERROR and bus_error is set.
  - mem_ready=1 in the same cycle as the limit wins: normal transition.
- mem_ready is ignored outside the wait states.
- Cycle counts with zero-wait memory:
  - R/I: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - JAL: 4
- Reset asserted mid-instruction aborts immediately; no partial write completes after rst_n falls.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
  - ALUOp codes: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - mux select encodings
  - 4-bit state enum
- One sub-module, riscv_mc_ctrl_decode: pure combinational state-to-control-vector table. The top-level keeps the state register, next-state logic, timeout counter and sticky flags.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB. alu_op=10 in EXEC_R; reg_write=1 and instr_retired=1 only in cycle 4.
- LW with mem_ready low 3 cycles in MEM_RD (MEM_TIMEOUT=16) -> mem_read held 4 cycles at adr_src=1, then MEM_WB with result_src=01, reg_write=1; 8 cycles total.
- BEQ with zero=1 then BEQ with zero=0 -> pc_write=1 in BRANCH only for the first; alu_op=01 in both.
- JAL -> pc_write=1 in the FETCH completion cycle and in JAL; reg_write=1 in ALU_WB with result_src=00.
- Opcode 0110111 -> ERROR after DECODE, illegal_instr=1, no strobes thereafter; rst_n pulse returns to FETCH with flags cleared.
- FETCH with mem_ready stuck 0, MEM_TIMEOUT=4 -> ERROR on the 5th edge, bus_error=1. Repeat with mem_ready=1 exactly at count 3 -> normal DECODE.
